// File: rtl/entropy_seq_ctrl.sv
// rtl/entropy_seq_ctrl.sv - JPEG entropy-decode sequencer: DC/AC phase, component/block walk, restarts, end of frame.
module entropy_seq_ctrl #(
    parameter int NUM_CH  = 3,
    parameter int MAX_BPC = 4,
    parameter int MCU_W   = 16,
    parameter int RI_W    = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BPC_W  = $clog2(MAX_BPC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CH_W:0]           cfg_num_ch,
    input  logic [NUM_CH*BPC_W-1:0] cfg_bpc,
    input  logic [MCU_W-1:0]        cfg_total_mcus,
    input  logic [RI_W-1:0]         cfg_restart_int,
    input  logic                    sym_valid,
    input  logic                    block_done,
    input  logic                    marker_seen,
    input  logic [2:0]              marker_idx,
    output logic [CH_W-1:0]         ch,
    output logic                    freq,
    output logic [NUM_CH-1:0]       dc_pred_clr,
    output logic                    resync_req,
    output logic                    busy,
    output logic                    frame_done,
    output logic [MCU_W-1:0]        mcu_cnt,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC,
        S_AC,
        S_RST_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CH_W:0]     num_ch_q;
    logic [BPC_W-1:0]  bpc_q [NUM_CH];
    logic [MCU_W-1:0]  total_q;
    logic [RI_W-1:0]   ri_q;
    logic [BPC_W-1:0]  blk;
    logic [RI_W-1:0]   rst_cnt;
    logic [2:0]        exp_idx;

    logic [CH_W:0]     num_ch_fix;
    logic [BPC_W-1:0]  bpc_cur;
    logic              last_blk;
    logic              last_ch;
    logic [MCU_W-1:0]  mcu_next;
    logic [RI_W-1:0]   rst_next;

    // Out-of-range component counts are clamped so ch never indexes past the bpc table.
    always_comb begin
        num_ch_fix = cfg_num_ch;
        if (cfg_num_ch == '0)
            num_ch_fix = (CH_W+1)'(1);
        else if (cfg_num_ch > (CH_W+1)'(NUM_CH))
            num_ch_fix = (CH_W+1)'(NUM_CH);
    end

    always_comb begin
        bpc_cur = bpc_q[0];
        for (int i = 1; i < NUM_CH; i++)
            if (ch == CH_W'(i))
                bpc_cur = bpc_q[i];
    end

    assign last_blk = ({1'b0, blk} + (BPC_W+1)'(1)) >= {1'b0, bpc_cur};
    assign last_ch  = ({1'b0, ch} + (CH_W+1)'(1)) >= num_ch_q;
    assign mcu_next = mcu_cnt + MCU_W'(1);
    assign rst_next = rst_cnt + RI_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ch          <= '0;
            freq        <= 1'b0;
            dc_pred_clr <= '0;
            resync_req  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            mcu_cnt     <= '0;
            err         <= 1'b0;
            num_ch_q    <= '0;
            total_q     <= '0;
            ri_q        <= '0;
            blk         <= '0;
            rst_cnt     <= '0;
            exp_idx     <= '0;
            for (int i = 0; i < NUM_CH; i++)
                bpc_q[i] <= '0;
        end else begin
            dc_pred_clr <= '0;
            frame_done  <= 1'b0;
            if (marker_seen && state != S_RST_WAIT)
                err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_ch_q <= num_ch_fix;
                        for (int i = 0; i < NUM_CH; i++)
                            bpc_q[i] <= (cfg_bpc[i*BPC_W +: BPC_W] == '0) ? BPC_W'(1)
                                                                          : cfg_bpc[i*BPC_W +: BPC_W];
                        total_q     <= (cfg_total_mcus == '0) ? MCU_W'(1) : cfg_total_mcus;
                        ri_q        <= cfg_restart_int;
                        ch          <= '0;
                        blk         <= '0;
                        mcu_cnt     <= '0;
                        rst_cnt     <= '0;
                        exp_idx     <= '0;
                        err         <= 1'b0;
                        freq        <= 1'b0;
                        busy        <= 1'b1;
                        dc_pred_clr <= '1;
                        state       <= S_DC;
                    end
                end
                S_DC: begin
                    if (block_done)
                        err <= 1'b1;
                    if (sym_valid) begin
                        freq  <= 1'b1;
                        state <= S_AC;
                    end
                end
                S_AC: begin
                    // A symbol arriving with block_done belongs to the block being closed.
                    if (block_done) begin
                        freq <= 1'b0;
                        if (!last_blk) begin
                            blk   <= blk + BPC_W'(1);
                            state <= S_DC;
                        end else if (!last_ch) begin
                            blk   <= '0;
                            ch    <= ch + CH_W'(1);
                            state <= S_DC;
                        end else begin
                            blk     <= '0;
                            ch      <= '0;
                            mcu_cnt <= mcu_next;
                            rst_cnt <= rst_next;
                            if (mcu_next == total_q) begin
                                frame_done <= 1'b1;
                                state      <= S_DONE;
                            end else if (ri_q != '0 && rst_next == ri_q) begin
                                resync_req <= 1'b1;
                                state      <= S_RST_WAIT;
                            end else begin
                                state <= S_DC;
                            end
                        end
                    end
                end
                S_RST_WAIT: begin
                    if (sym_valid || block_done)
                        err <= 1'b1;
                    if (marker_seen) begin
                        if (marker_idx != exp_idx)
                            err <= 1'b1;
                        dc_pred_clr <= '1;
                        rst_cnt     <= '0;
                        exp_idx     <= exp_idx + 3'd1;
                        resync_req  <= 1'b0;
                        state       <= S_DC;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
